// File: rtl/target_sequencer.sv
// Target sequencer for the reaction game. It takes qualified random values and lights one
// target LED at a time, then judges the button response and emits single-cycle hit/miss pulses.
module target_sequencer #(
    parameter int NUM_TARGETS = 8,
    parameter int CNT_W       = 26,
    parameter int SHOW_NORMAL = 50_000_000,
    parameter int SHOW_INTER  = 25_000_000,
    parameter int SHOW_ADV    = 12_500_000,
    parameter int GAP_CYCLES  = 5_000_000
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Start,
    input  logic [1:0]             i_GameSpeed,
    input  logic [3:0]             i_RandNum,
    input  logic                   i_RandValid,
    input  logic [NUM_TARGETS-1:0] i_Buttons,
    output logic [NUM_TARGETS-1:0] o_TargetLED,
    output logic                   o_HitPulse,
    output logic                   o_MissPulse,
    output logic                   o_Active
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_RAND = 2'd1;
    localparam logic [1:0] S_SHOW      = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    // Limits are held as terminal counts (length - 1) so the compare is a plain equality.
    localparam logic [CNT_W-1:0] LIM_NORMAL = CNT_W'(SHOW_NORMAL - 1);
    localparam logic [CNT_W-1:0] LIM_INTER  = CNT_W'(SHOW_INTER - 1);
    localparam logic [CNT_W-1:0] LIM_ADV    = CNT_W'(SHOW_ADV - 1);
    localparam logic [CNT_W-1:0] LIM_GAP    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [4:0]       NO_TARGET  = 5'(NUM_TARGETS);

    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_lim;
    logic [4:0]             r_last;
    logic [NUM_TARGETS-1:0] r_led;
    logic                   r_hit;
    logic                   r_miss;
    logic                   r_active;

    logic [CNT_W-1:0]       w_lim_sel;
    logic [NUM_TARGETS-1:0] w_onehot;
    logic                   w_rand_ok;
    logic                   w_wrong;
    logic                   w_right;
    logic                   w_timeout;

    always_comb begin
        w_lim_sel = LIM_ADV;
        case (i_GameSpeed)
            2'b00:   w_lim_sel = LIM_NORMAL;
            2'b01:   w_lim_sel = LIM_INTER;
            default: w_lim_sel = LIM_ADV;
        endcase
    end

    for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_dec
        assign w_onehot[i] = (i_RandNum == 4'(i));
    end

    assign w_rand_ok = i_RandValid && ({1'b0, i_RandNum} < NO_TARGET)
                       && ({1'b0, i_RandNum} != r_last);
    // Any off-target bit is a miss, even when the target bit is pressed in the same cycle.
    assign w_wrong   = |(i_Buttons & ~r_led);
    assign w_right   = |(i_Buttons & r_led);
    assign w_timeout = (r_cnt == r_lim);

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_lim    <= '0;
            r_last   <= NO_TARGET;
            r_led    <= '0;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            if (r_state != S_IDLE && !i_Start) begin
                // Abort drops the round silently; the last target is kept.
                r_state  <= S_IDLE;
                r_led    <= '0;
                r_active <= 1'b0;
                r_cnt    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt <= '0;
                        if (i_Start) r_state <= S_WAIT_RAND;
                    end
                    S_WAIT_RAND: begin
                        if (w_rand_ok) begin
                            r_led    <= w_onehot;
                            r_last   <= {1'b0, i_RandNum};
                            r_lim    <= w_lim_sel;
                            r_cnt    <= '0;
                            r_active <= 1'b1;
                            r_state  <= S_SHOW;
                        end
                    end
                    S_SHOW: begin
                        if (w_wrong || w_right || w_timeout) begin
                            r_hit    <= !w_wrong && w_right;
                            r_miss   <= w_wrong || !w_right;
                            r_led    <= '0;
                            r_active <= 1'b0;
                            r_cnt    <= '0;
                            r_state  <= S_GAP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (r_cnt == LIM_GAP) begin
                            r_cnt   <= '0;
                            r_state <= S_WAIT_RAND;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_TargetLED = r_led;
    assign o_HitPulse  = r_hit;
    assign o_MissPulse = r_miss;
    assign o_Active    = r_active;

endmodule

// File: tb/tb_target_sequencer.sv
// Scoreboard bench for target_sequencer: stimulus queues expected LIT/HIT/MISS events,
// a negedge monitor pops and compares them; timing is checked with bounded waits.
module tb_target_sequencer;
    localparam int NT = 8, SN = 12, SI = 8, SA = 4, GC = 3;
    localparam int K_LIT = 0, K_HIT = 1, K_MISS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, rv;
    logic [1:0]    spd;
    logic [3:0]    rn;
    logic [NT-1:0] btn;
    logic [NT-1:0] led;
    logic          hit, miss, act;

    target_sequencer #(
        .NUM_TARGETS(NT), .CNT_W(8), .SHOW_NORMAL(SN), .SHOW_INTER(SI),
        .SHOW_ADV(SA), .GAP_CYCLES(GC)
    ) dut (
        .i_Clock(clk), .i_Reset(rst_n), .i_Start(start), .i_GameSpeed(spd),
        .i_RandNum(rn), .i_RandValid(rv), .i_Buttons(btn),
        .o_TargetLED(led), .o_HitPulse(hit), .o_MissPulse(miss), .o_Active(act)
    );

    typedef struct { int kind; int val; } ev_t;
    ev_t q[$];
    int tests = 0, fails = 0;
    logic [NT-1:0] prev_led = '0;

    function automatic void chk(string nm, int a, int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endfunction

    function automatic void push(int k, int v);
        ev_t e;
        e.kind = k; e.val = v;
        q.push_back(e);
    endfunction

    function automatic void mon_ev(int k, int v);
        ev_t e;
        if (q.size() == 0) begin
            chk("unexpected_event", k, -1);
        end else begin
            e = q.pop_front();
            chk("ev_kind", k, e.kind);
            chk("ev_val", v, e.val);
        end
    endfunction

    always @(negedge clk) begin
        if (hit && miss) chk("hit_miss_exclusive", 1, 0);
        if (led != '0 && led != prev_led) mon_ev(K_LIT, int'(led));
        if (hit)  mon_ev(K_HIT, 0);
        if (miss) mon_ev(K_MISS, 0);
        prev_led = led;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic wait_sig(input int sel, output int n);
        bit done;
        n = 0; done = 0;
        while (!done) begin
            step();
            n++;
            case (sel)
                0:       done = (led != '0);
                1:       done = hit;
                default: done = miss;
            endcase
            if (!done && n >= 200) begin
                chk("wait_timeout", n, -1);
                done = 1;
            end
        end
    endtask

    task automatic accept(input int num, output int n);
        rn = 4'(num); rv = 1'b1;
        push(K_LIT, 1 << num);
        wait_sig(0, n);
        rv = 1'b0;
    endtask

    task automatic chk_idle_outs(input string nm);
        chk({nm, "_led"}, int'(led), 0);
        chk({nm, "_hit"}, int'(hit), 0);
        chk({nm, "_miss"}, int'(miss), 0);
        chk({nm, "_act"}, int'(act), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b1; rv = 1'b1; rn = 4'd3; spd = 2'b10; btn = '0;
        // Reset held with Start/RandValid active
        step(); chk_idle_outs("rst1");
        step(); chk_idle_outs("rst2");
        rst_n = 1'b1;
        step(); chk("idle_to_wait_led", int'(led), 0);
        push(K_LIT, 8);
        step(); chk("first_led", int'(led), 8); chk("first_act", int'(act), 1);
        rv = 1'b0;
        // Advanced timeout
        push(K_MISS, 0);
        wait_sig(2, n); chk("adv_timeout_n", n, SA);
        chk("timeout_led", int'(led), 0); chk("timeout_act", int'(act), 0);
        // Out-of-range and repeat rejection
        rn = 4'd12; rv = 1'b1;
        step(); chk("miss_one_cycle", int'(miss), 0);
        steps(7); chk("reject12", int'(led), 0);
        rn = 4'd9; steps(3); chk("reject9", int'(led), 0);
        rn = 4'd5; push(K_LIT, 32);
        step(); chk("accept5", int'(led), 32);
        rv = 1'b0;
        step(); btn = 8'h20; push(K_HIT, 0);
        step(); btn = '0;
        chk("hit5", int'(hit), 1); chk("hit5_nomiss", int'(miss), 0); chk("hit5_led", int'(led), 0);
        rn = 4'd5; rv = 1'b1;
        steps(8); chk("reject_repeat5", int'(led), 0);
        rn = 4'd2; push(K_LIT, 4);
        step(); chk("accept2", int'(led), 4);
        rv = 1'b0;
        btn = 8'h01; push(K_MISS, 0);
        step(); btn = '0;
        chk("wrong_miss", int'(miss), 1); chk("wrong_nohit", int'(hit), 0);
        // Target 6: hit, combined press, hit on the timeout cycle
        accept(6, n); chk("gap_len", n, GC + 1);
        step(); btn = 8'h40; push(K_HIT, 0);
        step(); btn = '0; chk("hit6", int'(hit), 1); chk("hit6_act", int'(act), 0);
        accept(1, n);
        push(K_MISS, 0); wait_sig(2, n); chk("adv_timeout1_n", n, SA);
        accept(6, n);
        step(); btn = 8'h41; push(K_MISS, 0);
        step(); btn = '0; chk("combo_miss", int'(miss), 1); chk("combo_nohit", int'(hit), 0);
        accept(3, n);
        steps(SA - 1); btn = 8'h08; push(K_HIT, 0);
        step(); btn = '0; chk("edge_hit", int'(hit), 1); chk("edge_nomiss", int'(miss), 0);
        step(); chk("edge_no_late_miss", int'(miss), 0);
        // Speed change mid-round applies to the next round only
        spd = 2'b00; accept(4, n);
        steps(2); spd = 2'b01;
        push(K_MISS, 0); wait_sig(2, n); chk("normal_held_n", n, SN - 2);
        accept(7, n);
        push(K_MISS, 0); wait_sig(2, n); chk("inter_n", n, SI);
        // Abort mid-SHOW
        accept(0, n);
        steps(2); start = 1'b0;
        step(); chk_idle_outs("abort");
        steps(5);
        start = 1'b1; rv = 1'b1; rn = 4'd0;
        steps(5); chk("last_kept", int'(led), 0);
        rn = 4'd6; spd = 2'b10; push(K_LIT, 64);
        step(); chk("accept6_after_abort", int'(led), 64);
        rv = 1'b0;
        push(K_MISS, 0); wait_sig(2, n); chk("adv_timeout6_n", n, SA);
        btn = 8'hFF; step(); btn = '0;
        chk("gap_press_hit", int'(hit), 0); chk("gap_press_miss", int'(miss), 0);
        // Reset mid-GAP clears LastTarget too
        rst_n = 1'b0; step(); chk_idle_outs("rst_gap");
        rst_n = 1'b1; rv = 1'b1; rn = 4'd6; push(K_LIT, 64);
        steps(2); chk("last_cleared", int'(led), 64);
        rv = 1'b0; step();
        rst_n = 1'b0; step(); chk_idle_outs("rst_show");
        rst_n = 1'b1;
        steps(3);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
